// File: rtl/divisor_pkg.sv
// -----------------------------------------------------------------------------
// divisor_pkg
// Shared types and defaults for the sequential restoring divider.
//   estado_t       : controller states (IDLE -> CALC -> DONE -> IDLE)
//   DEFAULT_WIDTH  : default operand / quotient / remainder width
// -----------------------------------------------------------------------------
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/subtrator_trial.sv
// -----------------------------------------------------------------------------
// subtrator_trial
// W-bit ripple-borrow subtractor computed as a + ~b + 1.
// Ports:
//   a      in   W   minuend
//   b      in   W   subtrahend
//   diff   out  W   a - b (modulo 2**W)
//   borrow out  1   1 when b > a (unsigned), i.e. no carry out of the top bit
// -----------------------------------------------------------------------------
module subtrator_trial #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // The carry-in of 1 supplies the "+1" of the two's complement of b.
  always_comb begin
    logic carry;
    diff  = '0;
    carry = 1'b1;
    for (int i = 0; i < W; i++) begin
      diff[i] = a[i] ^ ~b[i] ^ carry;
      carry   = (a[i] & ~b[i]) | (carry & (a[i] ^ ~b[i]));
    end
    borrow = ~carry;
  end

endmodule

// File: rtl/divisor_sequencial.sv
// -----------------------------------------------------------------------------
// divisor_sequencial
// Iterative restoring divider: one quotient bit per clock from a trial
// subtraction. Multi-cycle divide unit beside the add/sub datapath.
//
// Optional build macro: SIGNED_DIV_EN
//   defined   : a/b are two's complement; magnitudes are divided and the
//               signs restored on the outputs; ov flags MIN / -1.
//   undefined : unsigned operands, ov tied to 0, no negation hardware.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  dividend (sampled with start)
//   b      in   WIDTH  divisor  (sampled with start)
//   q      out  WIDTH  quotient
//   r      out  WIDTH  remainder
//   busy   out  1      high whenever the controller is not idle
//   done   out  1      one-cycle pulse, q/r/dz/ov valid in that cycle
//   dz     out  1      divide-by-zero flag
//   ov     out  1      signed overflow flag
//
// Handshake: start is accepted on a rising edge where busy is low; requests
// while busy are dropped, not queued. done pulses for exactly one cycle
// WIDTH+1 cycles after acceptance (1 cycle for b == 0); q/r/dz/ov then hold
// until the next accepted start. start held high in the cycle after done
// begins a new operation.
//
// Debug: the controller state is the internal signal "state" (estado_t).
// -----------------------------------------------------------------------------
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ov
);

  localparam int                CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  estado_t          state;
  estado_t          state_nxt;
  logic             accept;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;       // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] qr;        // quotient magnitude
  logic             dz_r;

  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;

  assign div_zero = (b == '0);

  // ---------------------------------------------------------------------------
  // Trial subtraction. Width WIDTH+1 so that the borrow is exact; rem_sh never
  // loses a bit because the remainder before the final step is below
  // 2**(WIDTH-1).
  // ---------------------------------------------------------------------------
  assign rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};

  subtrator_trial #(.W(WIDTH + 1)) u_trial (
    .a      ({1'b0, rem_sh}),
    .b      ({1'b0, dvs}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Borrow means the divisor did not fit: keep (restore) the shifted value.
  assign rem_step = trial_borrow ? rem_sh : trial_diff[WIDTH-1:0];
  assign q_step   = {qr[WIDTH-2:0], ~trial_borrow};

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? DONE : CALC;
        end
      end
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef SIGNED_DIV_EN
  // ---------------------------------------------------------------------------
  // Signed build: operands converted to magnitude on acceptance, signs kept
  // in sa/sb and reapplied combinationally on the outputs.
  // ---------------------------------------------------------------------------
  logic             sa;
  logic             sb;
  logic             ov_r;
  logic [WIDTH-1:0] a_neg;
  logic [WIDTH-1:0] b_neg;
  logic [WIDTH-1:0] q_neg;
  logic [WIDTH-1:0] r_neg;
  logic             nb_a;
  logic             nb_b;
  logic             nb_q;
  logic             nb_r;
  logic             unused_bits;

  subtrator_trial #(.W(WIDTH)) u_neg_a (
    .a ('0), .b (a),   .diff (a_neg), .borrow (nb_a)
  );
  subtrator_trial #(.W(WIDTH)) u_neg_b (
    .a ('0), .b (b),   .diff (b_neg), .borrow (nb_b)
  );
  subtrator_trial #(.W(WIDTH)) u_neg_q (
    .a ('0), .b (qr),  .diff (q_neg), .borrow (nb_q)
  );
  subtrator_trial #(.W(WIDTH)) u_neg_r (
    .a ('0), .b (rem), .diff (r_neg), .borrow (nb_r)
  );

  // MIN negates to itself, which is also its correct unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? a_neg : a;
  assign b_mag = b[WIDTH-1] ? b_neg : b;

  assign q  = (sa ^ sb) ? q_neg : qr;
  assign r  = sa ? r_neg : rem;
  assign dz = dz_r;
  assign ov = ov_r;

  assign unused_bits = ^{nb_a, nb_b, nb_q, nb_r, trial_diff[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= 1'b0;
      sb   <= 1'b0;
      ov_r <= 1'b0;
    end else if (accept) begin
      // Divide by zero returns raw a and all ones, so no sign is reapplied.
      sa   <= div_zero ? 1'b0 : a[WIDTH-1];
      sb   <= div_zero ? 1'b0 : b[WIDTH-1];
      ov_r <= 1'b0;
    end else if (state == CALC && cnt == '0) begin
      // A positive quotient of magnitude 2**(WIDTH-1) only arises from MIN/-1.
      ov_r <= (q_step == MSB_ONLY) && (sa == sb);
    end
  end
`else
  logic unused_bits;

  assign a_mag = a;
  assign b_mag = b;

  assign q  = qr;
  assign r  = rem;
  assign dz = dz_r;
  assign ov = 1'b0;

  assign unused_bits = trial_diff[WIDTH];
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      qr   <= '0;
      dz_r <= 1'b0;
    end else if (accept) begin
      dz_r <= div_zero;
      if (div_zero) begin
        qr  <= '1;
        rem <= a;
      end else begin
        dvd <= a_mag;
        dvs <= b_mag;
        rem <= '0;
        qr  <= '0;
        cnt <= CNT_LAST;
      end
    end else if (state == CALC) begin
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      rem <= rem_step;
      qr  <= q_step;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule
